// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle between the two command requesters, the SPI RAM port and the arbiter.
// The slave modport is the arbiter side; master is the side that drives requests and RAM returns.
interface spi_ram_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W+1:0] req0_data;
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W+1:0] req1_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W+1:0] ram_din;
  logic              ram_rx_valid;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_tx_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_valid;

  modport slave (
    input  req0_data, req0_valid, req1_data, req1_valid, ram_dout, ram_tx_valid,
    output req0_ready, req1_ready, ram_din, ram_rx_valid,
    output rsp0_data, rsp0_valid, rsp1_data, rsp1_valid
  );

  modport master (
    output req0_data, req0_valid, req1_data, req1_valid, ram_dout, ram_tx_valid,
    input  req0_ready, req1_ready, ram_din, ram_rx_valid,
    input  rsp0_data, rsp0_valid, rsp1_data, rsp1_valid
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter for the single-port SPI RAM: locks ownership across each
// address/data word pair, forwards words to the RAM and steers read data back to the owner.
module spi_ram_arbiter #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned HOLD_TIMEOUT = 16,
  parameter int unsigned RSP_TIMEOUT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_ram_arbiter_if.slave bus,
  output logic             owner,
  output logic             busy,
  output logic             timeout_err
);
  localparam int unsigned WordW = DATA_W + 2;
  localparam int unsigned HoldW = $clog2(HOLD_TIMEOUT + 1);
  localparam int unsigned RspW  = $clog2(RSP_TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TIMEOUT - 1);
  localparam logic [RspW-1:0]  RspLast  = RspW'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StHoldWr, StHoldRd, StWaitRsp} state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [RspW-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic              owner_q, rr_q;
  logic              ready0, ready1, accept, sel;
  logic [WordW-1:0]  word;
  logic [1:0]        cmd;
  logic              tmo_d, rsp_fire;
  logic [WordW-1:0]  ram_din_q;
  logic              ram_rx_valid_q;
  logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;
  logic              rsp0_valid_q, rsp1_valid_q, timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      rsp_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
    end
  end

  // Acceptance: in IDLE the rr pointer holds the last grantee, so a tie goes to the other one.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req0_valid && bus.req1_valid) begin
          ready0 = rr_q;
          ready1 = !rr_q;
        end else begin
          ready0 = bus.req0_valid;
          ready1 = bus.req1_valid;
        end
      end
      StHoldWr, StHoldRd: begin
        ready0 = bus.req0_valid && !owner_q;
        ready1 = bus.req1_valid && owner_q;
      end
      default: ;
    endcase
  end

  assign accept = ready0 || ready1;
  assign sel    = ready1;
  assign word   = sel ? bus.req1_data : bus.req0_data;
  assign cmd    = word[WordW-1:DATA_W];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    rsp_cnt_d  = '0;
    tmo_d      = 1'b0;
    rsp_fire   = 1'b0;
    if (accept) begin
      unique case (cmd)
        2'b00: state_d = StHoldWr;
        2'b10: state_d = StHoldRd;
        2'b01: state_d = StIdle;
        2'b11: state_d = StWaitRsp;
      endcase
    end else begin
      case (state_q)
        StHoldWr, StHoldRd: begin
          if (hold_cnt_q == HoldLast) begin
            state_d = StIdle;
            tmo_d   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
        StWaitRsp: begin
          // A response on the expiry cycle still wins over the timeout.
          if (bus.ram_tx_valid) begin
            state_d  = StIdle;
            rsp_fire = 1'b1;
          end else if (rsp_cnt_q == RspLast) begin
            state_d = StIdle;
            tmo_d   = 1'b1;
          end else begin
            rsp_cnt_d = rsp_cnt_q + RspW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q        <= 1'b0;
      rr_q           <= 1'b1;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rsp0_data_q    <= '0;
      rsp0_valid_q   <= 1'b0;
      rsp1_data_q    <= '0;
      rsp1_valid_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      ram_rx_valid_q <= accept;
      if (accept) begin
        ram_din_q <= word;
        owner_q   <= sel;
      end
      if (accept && state_q == StIdle) rr_q <= sel;
      rsp0_valid_q <= rsp_fire && !owner_q;
      rsp1_valid_q <= rsp_fire && owner_q;
      if (rsp_fire && !owner_q) rsp0_data_q <= bus.ram_dout;
      if (rsp_fire && owner_q) rsp1_data_q <= bus.ram_dout;
      timeout_err_q <= tmo_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.ram_din      = ram_din_q;
  assign bus.ram_rx_valid = ram_rx_valid_q;
  assign bus.rsp0_data    = rsp0_data_q;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp1_data    = rsp1_data_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign owner            = owner_q;
  assign busy             = (state_q != StIdle);
  assign timeout_err      = timeout_err_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: stimulus pushes expected RAM words, responses and
// timeout pulses into queues; a negedge monitor pops and compares whenever the DUT emits one.
module tb_spi_ram_arbiter;
  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic owner, busy, timeout_err;

  always #5 clk = ~clk;

  spi_ram_arbiter_if #(.DATA_W(DATA_W)) bus ();

  spi_ram_arbiter #(
    .DATA_W      (DATA_W),
    .HOLD_TIMEOUT(16),
    .RSP_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .owner      (owner),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;
  logic [9:0] exp_ram[$];
  logic [7:0] exp_rsp0[$];
  logic [7:0] exp_rsp1[$];
  bit         exp_tmo[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [9:0] d0, input bit v1, input logic [9:0] d1);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.ram_rx_valid) begin
      check("ram_pending", exp_ram.size() != 0, 1);
      if (exp_ram.size() != 0) check("ram_din", bus.ram_din, exp_ram.pop_front());
    end
    if (bus.rsp0_valid) begin
      check("rsp0_pending", exp_rsp0.size() != 0, 1);
      if (exp_rsp0.size() != 0) check("rsp0_data", bus.rsp0_data, exp_rsp0.pop_front());
    end
    if (bus.rsp1_valid) begin
      check("rsp1_pending", exp_rsp1.size() != 0, 1);
      if (exp_rsp1.size() != 0) check("rsp1_data", bus.rsp1_data, exp_rsp1.pop_front());
    end
    if (bus.rsp0_valid && bus.rsp1_valid) check("rsp_exclusive", 2, 1);
    if (timeout_err) begin
      check("tmo_pending", exp_tmo.size() != 0, 1);
      if (exp_tmo.size() != 0) void'(exp_tmo.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 10'h0, 0, 10'h0);
    bus.ram_dout     = 8'h00;
    bus.ram_tx_valid = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", bus.ram_rx_valid, 0);
    check("rst_ram_din", bus.ram_din, 0);
    check("rst_rsp0", {bus.rsp0_valid, bus.rsp0_data}, 0);
    check("rst_rsp1", {bus.rsp1_valid, bus.rsp1_data}, 0);
    check("rst_tmo", timeout_err, 0);
    step();

    // Tie after reset: req0 first, then req1
    drive(1, 10'h001, 1, 10'h244);
    @(negedge clk);
    check("tie_rdy0", bus.req0_ready, 1);
    check("tie_rdy1", bus.req1_ready, 0);
    exp_ram.push_back(10'h001);
    step();
    drive(1, 10'h177, 1, 10'h244);
    @(negedge clk);
    check("tie_hold_rdy0", bus.req0_ready, 1);
    check("tie_hold_rdy1", bus.req1_ready, 0);
    exp_ram.push_back(10'h177);
    step();
    drive(0, 10'h0, 1, 10'h244);
    @(negedge clk);
    check("tie_next_rdy1", bus.req1_ready, 1);
    exp_ram.push_back(10'h244);
    step();
    drive(0, 10'h0, 1, 10'h133);
    @(negedge clk);
    check("tie_owner1", owner, 1);
    check("tie_data_rdy1", bus.req1_ready, 1);
    exp_ram.push_back(10'h133);
    step();
    drive(0, 10'h0, 0, 10'h0);

    // Single write by req0; req1 locked out during HOLD_WR
    drive(1, 10'h0A5, 0, 10'h0);
    @(negedge clk);
    check("wr_rdy0_a", bus.req0_ready, 1);
    exp_ram.push_back(10'h0A5);
    step();
    drive(1, 10'h13C, 1, 10'h0FF);
    @(negedge clk);
    check("wr_busy", busy, 1);
    check("wr_rdy1_locked", bus.req1_ready, 0);
    check("wr_rdy0_d", bus.req0_ready, 1);
    exp_ram.push_back(10'h13C);
    step();
    drive(0, 10'h0, 0, 10'h0);
    step();
    @(negedge clk);
    check("wr_idle", busy, 0);
    check("wr_din_hold", {bus.ram_rx_valid, bus.ram_din}, {1'b0, 10'h13C});
    step();

    // Read with lock by req1 while req0 is held valid
    drive(1, 10'h0C3, 1, 10'h210);
    @(negedge clk);
    check("rd_rdy1_a", bus.req1_ready, 1);
    check("rd_rdy0_a", bus.req0_ready, 0);
    exp_ram.push_back(10'h210);
    step();
    drive(1, 10'h0C3, 1, 10'h300);
    @(negedge clk);
    check("rd_owner", owner, 1);
    check("rd_rdy1_d", bus.req1_ready, 1);
    check("rd_rdy0_d", bus.req0_ready, 0);
    exp_ram.push_back(10'h300);
    step();
    drive(1, 10'h0C3, 0, 10'h0);
    @(negedge clk);
    check("rd_wait_rdy0", bus.req0_ready, 0);
    check("rd_wait_busy", busy, 1);
    step();
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'h5A;
    exp_rsp1.push_back(8'h5A);
    @(negedge clk);
    check("rd_tx_rdy0", bus.req0_ready, 0);
    step();
    bus.ram_tx_valid = 1'b0;
    @(negedge clk);
    check("rd_rsp1_valid", bus.rsp1_valid, 1);
    check("rd_then_rdy0", bus.req0_ready, 1);
    exp_ram.push_back(10'h0C3);
    step();
    drive(1, 10'h1EE, 0, 10'h0);
    @(negedge clk);
    check("rd_req0_data_rdy", bus.req0_ready, 1);
    exp_ram.push_back(10'h1EE);
    step();
    drive(0, 10'h0, 0, 10'h0);

    // Hold timeout: req0 goes silent after an address word, req1 waiting
    drive(1, 10'h010, 0, 10'h0);
    @(negedge clk);
    check("ht_rdy0", bus.req0_ready, 1);
    exp_ram.push_back(10'h010);
    step();
    drive(0, 10'h0, 1, 10'h2AB);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("ht_rdy1_locked", bus.req1_ready, 0);
      check("ht_busy", busy, 1);
      if (i == 16) exp_tmo.push_back(1'b1);
      step();
    end
    @(negedge clk);
    check("ht_idle", busy, 0);
    check("ht_tmo_pulse", timeout_err, 1);
    check("ht_rdy1_granted", bus.req1_ready, 1);
    exp_ram.push_back(10'h2AB);
    step();

    // Response timeout: read-data forwarded, RAM stays silent
    drive(0, 10'h0, 1, 10'h300);
    @(negedge clk);
    check("rt_rdy1", bus.req1_ready, 1);
    exp_ram.push_back(10'h300);
    step();
    drive(0, 10'h0, 0, 10'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("rt_busy", busy, 1);
      if (i == 8) exp_tmo.push_back(1'b1);
      step();
    end
    @(negedge clk);
    check("rt_idle", busy, 0);
    check("rt_tmo_pulse", timeout_err, 1);
    check("rt_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    step();
    // Stray RAM data in IDLE is dropped
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'hEE;
    step();
    bus.ram_tx_valid = 1'b0;
    @(negedge clk);
    check("stray_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    step();

    // Response exactly on the last wait cycle wins over the timeout
    drive(1, 10'h280, 0, 10'h0);
    @(negedge clk);
    check("re_rdy0_a", bus.req0_ready, 1);
    exp_ram.push_back(10'h280);
    step();
    drive(1, 10'h3FF, 0, 10'h0);
    @(negedge clk);
    check("re_rdy0_d", bus.req0_ready, 1);
    exp_ram.push_back(10'h3FF);
    step();
    drive(0, 10'h0, 0, 10'h0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("re_busy", busy, 1);
      step();
    end
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'hA7;
    exp_rsp0.push_back(8'hA7);
    @(negedge clk);
    check("re_busy_last", busy, 1);
    step();
    bus.ram_tx_valid = 1'b0;
    @(negedge clk);
    check("re_idle", busy, 0);
    check("re_rsp0", {bus.rsp0_valid, bus.rsp0_data}, {1'b1, 8'hA7});
    check("re_no_tmo", timeout_err, 0);
    check("re_rsp1_held", bus.rsp1_data, 8'h5A);
    step();

    // Reset in the middle of a read
    drive(0, 10'h0, 1, 10'h2CD);
    @(negedge clk);
    check("mr_rdy1", bus.req1_ready, 1);
    exp_ram.push_back(10'h2CD);
    step();
    drive(0, 10'h0, 0, 10'h0);
    rst = 1'b1;
    @(negedge clk);
    check("mr_busy_before", busy, 1);
    step();
    @(negedge clk);
    check("mr_busy", busy, 0);
    check("mr_owner", owner, 0);
    check("mr_ram", {bus.ram_rx_valid, bus.ram_din}, 0);
    check("mr_rsp", {bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid, bus.rsp1_data}, 0);
    check("mr_tmo", timeout_err, 0);
    step();
    rst = 1'b0;
    bus.ram_tx_valid = 1'b1;
    bus.ram_dout     = 8'h99;
    step();
    bus.ram_tx_valid = 1'b0;
    @(negedge clk);
    check("mr_late_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    step();
    step();

    check("ram_q_empty", exp_ram.size(), 0);
    check("rsp0_q_empty", exp_rsp0.size(), 0);
    check("rsp1_q_empty", exp_rsp1.size(), 0);
    check("tmo_q_empty", exp_tmo.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
